pattern_sequencer: RTL and testbench
====================================

// Module: pattern_sequencer
// PURPOSE
//  Selects which test pattern the pixel datapath renders (colour bars, solid fills, etc.).
//  Supports manual stepping from a raw push-button and an auto-cycle mode driven by frame count.
//  Pattern changes are applied only at frame boundaries, so a frame never shows two patterns.
//  Sits between board I/O and the pattern mux that feeds the VGA colour outputs.
// PARAMETERS
//  NUM_PATTERNS     8        number of selectable patterns; legal range 1..8
//  DEBOUNCE_CYCLES  500000   consecutive stable clk cycles required to accept a button level (10 ms @ 50 MHz)
//  AUTO_FRAMES      120      frames each pattern is held in auto mode; legal range >= 1
// PORTS
//  clk             in   1  pixel/system clock
//  reset           in   1  synchronous, active-high
//  frame_start     in   1  one-cycle pulse at start of vertical blanking, from the sync generator
//  btn_next        in   1  raw, asynchronous, active-high "next pattern" button
//  auto_en         in   1  level; 1 requests auto-cycle mode
//  pattern_sel     out  3  current pattern index, 0..NUM_PATTERNS-1
//  pattern_update  out  1  one-cycle pulse when an advance is committed
//  auto_active     out  1  1 while the FSM is in AUTO
// BEHAVIOUR
//  - Reset (synchronous, active-high):
//    - outputs: pattern_sel=0, pattern_update=0, auto_active=0
//    - internal: state=MANUAL, sync flops=0, debounced level=0, debounce cnt=0, pend_next=0, frame_cnt=0
//  - Button input path:
//    - 2-FF synchroniser, then debounce counter.
//    - Counter resets whenever the synced level equals the debounced level.
//    - Debounced level flips when the synced level differs for DEBOUNCE_CYCLES consecutive cycles.
//  - Pending request:
//    - Rising edge of the debounced level sets sticky pend_next.
//    - Multiple edges before the next frame_start collapse into one request.
//    - An edge in the same cycle as frame_start is honoured at that frame_start.
//  - FSM, states MANUAL / AUTO; transitions only on cycles with frame_start=1:
//    - MANUAL -> AUTO when auto_en=1; frame_cnt cleared.
//    - AUTO -> MANUAL when auto_en=0; frame_cnt cleared.
//    - auto_en changes between frame_starts have no effect until the next frame_start.
//  - Advance condition, evaluated on a frame_start cycle using the pre-transition state:
//    - pend_next=1 (either state), or
//    - state=AUTO and frame_cnt==AUTO_FRAMES-1.
//  - In AUTO, each frame_start without an advance increments frame_cnt; an advance clears it.
//  - Button advance plus auto expiry on the same frame_start gives one step only.
//  - Advance actions:
//    - pattern_sel <= (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1
//    - pattern_update <= 1 for exactly one cycle
//    - pend_next <= 0
//    - Both outputs change 1 clk after the frame_start cycle (latency 1).
//  - NUM_PATTERNS=1: pattern_sel stays 0; pattern_update still pulses on each advance.
//  - auto_active is registered: auto_active <= (next state == AUTO).
//  - reset asserted mid-debounce or with a request pending: all state dropped, no pattern_update.
// CONFIGURATION
//  PAT_SEQ_PREV_EN defined:
//    - Adds port btn_prev (in, 1, raw async active-high) with its own sync/debounce and sticky pend_prev.
//    - Retreat: pattern_sel <= (pattern_sel==0) ? NUM_PATTERNS-1 : pattern_sel-1, with pattern_update and cleared frame_cnt.
//    - pend_prev alone (auto expiry or not) -> one retreat.
//    - pend_next and pend_prev both set at frame_start -> the two cancel: no pattern change, no
//      pattern_update, both cleared, frame_cnt still cleared in AUTO.
//  PAT_SEQ_PREV_EN undefined:
//    - btn_prev port and its logic do not exist; behaviour as above.
// TESTING  (bench params: NUM_PATTERNS=4, DEBOUNCE_CYCLES=4, AUTO_FRAMES=3)
//  1. reset high 2 cycles -> pattern_sel=0, pattern_update=0, auto_active=0; frame_starts with no input -> no change.
//  2. btn_next high 3 cycles then low -> no debounced edge; frame_start -> pattern_sel stays 0, no pulse.
//  3. btn_next held 10 cycles, then frame_start -> 1 clk later pattern_sel=1 with single pattern_update pulse.
//  4. Three debounced presses before one frame_start -> pattern_sel advances by exactly 1.
//  5. pattern_sel=3, press + frame_start -> pattern_sel=0 (wrap).
//  6. auto_en=1 at frame_start F0 -> auto_active=1; pattern_sel advances at F3, F6, F9.
//     A press committed at F4 -> step at F4, next auto step at F7; auto_en=0 -> MANUAL at next frame_start.
//  (PAT_SEQ_PREV_EN) pattern_sel=0, btn_prev press -> 3.
//  (PAT_SEQ_PREV_EN) next and prev both pending at one frame_start -> unchanged, no pulse.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Test-pattern selector: debounced manual stepping plus frame-counted auto-cycle, committed at frame_start.
// Optional macro PAT_SEQ_PREV_EN adds a debounced btn_prev input that steps the pattern backwards.
module pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS    = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned AUTO_FRAMES     = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       btn_next,
`ifdef PAT_SEQ_PREV_EN
    input  logic       btn_prev,
`endif
    input  logic       auto_en,
    output logic [2:0] pattern_sel,
    output logic       pattern_update,
    output logic       auto_active
);
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned FcW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [DbW-1:0] DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FcW-1:0] FcLast  = FcW'(AUTO_FRAMES - 1);
    localparam logic [2:0]     SelLast = 3'(NUM_PATTERNS - 1);

    typedef enum logic [0:0] {StManual, StAuto} state_e;

    state_e         state_q;
    logic [FcW-1:0] frame_cnt_q;

    logic           nsync1_q, nsync2_q, ndeb_q;
    logic [DbW-1:0] ncnt_q;
    logic           pend_next_q;
    logic           pend_next_eff;

    logic           pend_prev_eff;
    logic           expire, do_adv, do_ret, step;
    logic [2:0]     sel_inc, sel_dec;

    // A rise on the final stable cycle counts as pending in that same cycle.
    assign pend_next_eff = pend_next_q | (nsync2_q & ~ndeb_q & (ncnt_q == DbLast));

    always_ff @(posedge clk) begin
        if (reset) begin
            nsync1_q <= 1'b0;
            nsync2_q <= 1'b0;
            ndeb_q   <= 1'b0;
            ncnt_q   <= '0;
        end else begin
            nsync1_q <= btn_next;
            nsync2_q <= nsync1_q;
            if (nsync2_q == ndeb_q) begin
                ncnt_q <= '0;
            end else if (ncnt_q == DbLast) begin
                ndeb_q <= nsync2_q;
                ncnt_q <= '0;
            end else begin
                ncnt_q <= ncnt_q + DbW'(1);
            end
        end
    end

`ifdef PAT_SEQ_PREV_EN
    logic           psync1_q, psync2_q, pdeb_q;
    logic [DbW-1:0] pcnt_q;
    logic           pend_prev_q;

    assign pend_prev_eff = pend_prev_q | (psync2_q & ~pdeb_q & (pcnt_q == DbLast));

    always_ff @(posedge clk) begin
        if (reset) begin
            psync1_q    <= 1'b0;
            psync2_q    <= 1'b0;
            pdeb_q      <= 1'b0;
            pcnt_q      <= '0;
            pend_prev_q <= 1'b0;
        end else begin
            psync1_q    <= btn_prev;
            psync2_q    <= psync1_q;
            pend_prev_q <= frame_start ? 1'b0 : pend_prev_eff;
            if (psync2_q == pdeb_q) begin
                pcnt_q <= '0;
            end else if (pcnt_q == DbLast) begin
                pdeb_q <= psync2_q;
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + DbW'(1);
            end
        end
    end
`else
    assign pend_prev_eff = 1'b0;
`endif

    always_comb begin
        expire  = (state_q == StAuto) && (frame_cnt_q == FcLast);
        // Simultaneous next and prev requests cancel; auto expiry is then ignored too.
        do_adv  = (pend_next_eff & ~pend_prev_eff) | (~pend_next_eff & ~pend_prev_eff & expire);
        do_ret  = pend_prev_eff & ~pend_next_eff;
        step    = pend_next_eff | pend_prev_eff | expire;
        sel_inc = (pattern_sel == SelLast) ? 3'd0 : pattern_sel + 3'd1;
        sel_dec = (pattern_sel == 3'd0) ? SelLast : pattern_sel - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StManual;
            frame_cnt_q    <= '0;
            pend_next_q    <= 1'b0;
            pattern_sel    <= 3'd0;
            pattern_update <= 1'b0;
            auto_active    <= 1'b0;
        end else begin
            pattern_update <= 1'b0;
            pend_next_q    <= pend_next_eff;
            if (frame_start) begin
                pend_next_q <= 1'b0;
                if (do_adv) begin
                    pattern_sel    <= sel_inc;
                    pattern_update <= 1'b1;
                end else if (do_ret) begin
                    pattern_sel    <= sel_dec;
                    pattern_update <= 1'b1;
                end
                if (((state_q == StAuto) != auto_en) || step) begin
                    frame_cnt_q <= '0;
                end else if (state_q == StAuto) begin
                    frame_cnt_q <= frame_cnt_q + FcW'(1);
                end
                state_q     <= auto_en ? StAuto : StManual;
                auto_active <= auto_en;
            end
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomised and directed bench for pattern_sequencer against a behavioural model.
// Define PAT_SEQ_PREV_EN on both files to exercise the btn_prev path.
module tb_pattern_sequencer;
    localparam int NP = 4;
    localparam int DB = 4;
    localparam int AF = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic [2:0] pattern_sel;
    logic       pattern_update;
    logic       auto_active;

    int errors = 0;
    int checks = 0;

    pattern_sequencer #(
        .NUM_PATTERNS   (NP),
        .DEBOUNCE_CYCLES(DB),
        .AUTO_FRAMES    (AF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .btn_next      (btn_next),
`ifdef PAT_SEQ_PREV_EN
        .btn_prev      (btn_prev),
`endif
        .auto_en       (auto_en),
        .pattern_sel   (pattern_sel),
        .pattern_update(pattern_update),
        .auto_active   (auto_active)
    );

    always #5 clk = ~clk;

    // Model state: button history as a shift register of synced samples.
    int        m_sel, m_fcnt;
    bit        m_upd, m_auto;
    bit        m_pend[2], m_s1[2], m_s2[2], m_deb[2];
    bit [31:0] m_hist[2];

    task automatic model_btn(input int b, input bit raw, output bit rise);
        bit [31:0] mask;
        mask = (32'd1 << DB) - 32'd1;
        m_hist[b] = {m_hist[b][30:0], m_s2[b]};
        rise = 1'b0;
        if (!m_deb[b] && ((m_hist[b] & mask) == mask)) begin
            m_deb[b] = 1'b1;
            rise = 1'b1;
        end else if (m_deb[b] && ((m_hist[b] & mask) == 32'd0)) begin
            m_deb[b] = 1'b0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw;
    endtask

    task automatic model_step();
        bit rn, rp, pn, pp, expire;
        if (reset) begin
            m_sel = 0; m_fcnt = 0; m_upd = 0; m_auto = 0;
            for (int b = 0; b < 2; b++) begin
                m_pend[b] = 0; m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_hist[b] = 0;
            end
            return;
        end
        model_btn(0, btn_next, rn);
        pn = m_pend[0] | rn;
`ifdef PAT_SEQ_PREV_EN
        model_btn(1, btn_prev, rp);
        pp = m_pend[1] | rp;
`else
        rp = 1'b0;
        pp = rp;
`endif
        m_upd = 1'b0;
        if (frame_start) begin
            expire = m_auto && (m_fcnt == AF - 1);
            if (pn && pp) begin
                // cancel: no change
            end else if (pp) begin
                m_sel = (m_sel + NP - 1) % NP;
                m_upd = 1'b1;
            end else if (pn || expire) begin
                m_sel = (m_sel + 1) % NP;
                m_upd = 1'b1;
            end
            if ((m_auto != auto_en) || pn || pp || expire) m_fcnt = 0;
            else if (m_auto) m_fcnt = m_fcnt + 1;
            m_auto = auto_en;
            pn = 1'b0;
            pp = 1'b0;
        end
        m_pend[0] = pn;
        m_pend[1] = pp;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pattern_sel", int'(pattern_sel), m_sel);
        check("pattern_update", int'(pattern_update), int'(m_upd));
        check("auto_active", int'(auto_active), int'(m_auto));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic press(input bit nxt, input bit prv);
        btn_next = nxt;
        btn_prev = prv;
        idle(8);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        idle(8);
    endtask

    initial begin
        int fs_gap, nhold, phold;

        // Reset and idle frames
        idle(2);
        check("lit_reset_sel", int'(pattern_sel), 0);
        check("lit_reset_upd", int'(pattern_update), 0);
        check("lit_reset_auto", int'(auto_active), 0);
        reset = 1'b0;
        idle(2);
        frame(); idle(3); frame();
        check("lit_idle_sel", int'(pattern_sel), 0);

        // Too-short press is rejected
        btn_next = 1'b1; idle(3); btn_next = 1'b0; idle(8);
        frame();
        check("lit_short_sel", int'(pattern_sel), 0);
        check("lit_short_upd", int'(pattern_update), 0);

        // Held press commits at the next frame
        btn_next = 1'b1; idle(10); btn_next = 1'b0;
        frame();
        check("lit_press_sel", int'(pattern_sel), 1);
        check("lit_press_upd", int'(pattern_update), 1);
        tick();
        check("lit_press_upd_drop", int'(pattern_update), 0);
        idle(8);

        // Three presses collapse into one step
        press(1, 0); press(1, 0); press(1, 0);
        frame();
        check("lit_collapse_sel", int'(pattern_sel), 2);

        // Wrap
        press(1, 0); frame();
        check("lit_sel3", int'(pattern_sel), 3);
        press(1, 0); frame();
        check("lit_wrap_sel", int'(pattern_sel), 0);

        // Pending request dropped by reset
        press(1, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        frame();
        check("lit_rst_pend_sel", int'(pattern_sel), 0);
        check("lit_rst_pend_upd", int'(pattern_update), 0);

`ifdef PAT_SEQ_PREV_EN
        press(0, 1); frame();
        check("lit_prev_wrap", int'(pattern_sel), 3);
        press(1, 1); frame();
        check("lit_cancel_sel", int'(pattern_sel), 3);
        check("lit_cancel_upd", int'(pattern_update), 0);
        press(1, 0); frame();
        check("lit_back_to0", int'(pattern_sel), 0);
`endif

        // Auto mode: F0 enters, steps at F3, press at F4, next auto step at F7
        auto_en = 1'b1;
        frame();
        check("lit_auto_on", int'(auto_active), 1);
        for (int f = 1; f <= 7; f++) begin
            if (f == 4) press(1, 0); else idle(3);
            frame();
            if (f == 2) check("lit_auto_f2", int'(pattern_sel), 0);
            if (f == 3) check("lit_auto_f3", int'(pattern_sel), 1);
            if (f == 4) check("lit_auto_f4", int'(pattern_sel), 2);
            if (f == 6) check("lit_auto_f6", int'(pattern_sel), 2);
            if (f == 7) check("lit_auto_f7", int'(pattern_sel), 3);
        end
        auto_en = 1'b0;
        idle(3);
        check("lit_auto_hold", int'(auto_active), 1);
        frame();
        check("lit_auto_off", int'(auto_active), 0);
        check("lit_auto_off_sel", int'(pattern_sel), 3);

        // Randomised traffic
        fs_gap = 5; nhold = 1; phold = 1;
        for (int c = 0; c < 6000; c++) begin
            nhold--;
            if (nhold == 0) begin
                btn_next = ~btn_next;
                nhold = $urandom_range(1, 9);
            end
`ifdef PAT_SEQ_PREV_EN
            phold--;
            if (phold == 0) begin
                btn_prev = ~btn_prev;
                phold = $urandom_range(1, 11);
            end
`endif
            fs_gap--;
            frame_start = (fs_gap == 0);
            if (fs_gap == 0) fs_gap = $urandom_range(2, 14);
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end
        frame_start = 1'b0;
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
